// File: rtl/dog.sv
// Difference-of-Gaussian front end.
// Takes a raster-order 8-bit pixel stream, one pixel per clk, and forms a 5x5 window from four
// line buffers plus a column register. Four separable 5-tap Gaussian kernels, each with taps
// summing to 32, produce unnormalized 2-D sums (scale 1024). The three adjacent-scale absolute
// differences are reduced to 8 bits by dropping the low 10 bits.
//
// Ports:
//   clk                  pixel clock, rising edge
//   rst                  asynchronous active-low reset
//   clk_90               quadrature clock, reserved and unused
//   din[7:0]             input pixel, sampled every clk after reset release
//   dout1..dout4[17:0]   Gaussian sums G1..G4 of the window centre
//   diff0..diff2[7:0]    |G1-G2|, |G2-G3|, |G3-G4| bits [17:10]
//   out_en               outputs valid this cycle
//   addr[20:0]           raster index of the window centre pixel
//   complete1            last input pixel of the frame has reached the output stage
//   complete2            last valid output of the frame is being presented
module dog #(
   parameter int unsigned IMG_W = 640,
   parameter int unsigned IMG_H = 480
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clk_90,
   input  logic [7:0]  din,
   output logic [17:0] dout1,
   output logic [17:0] dout2,
   output logic [17:0] dout3,
   output logic [17:0] dout4,
   output logic [7:0]  diff0,
   output logic [7:0]  diff1,
   output logic [7:0]  diff2,
   output logic        out_en,
   output logic [20:0] addr,
   output logic        complete1,
   output logic        complete2
);

   localparam int unsigned CW = $clog2(IMG_W);
   localparam int unsigned RW = $clog2(IMG_H);
   localparam logic [CW-1:0] ColLast = CW'(IMG_W - 1);
   localparam logic [RW-1:0] RowLast = RW'(IMG_H - 1);
   localparam logic [20:0]   PixLast = 21'(IMG_W * IMG_H - 1);
   // Offset from the bottom-right pixel back to the window centre.
   localparam logic [20:0]   CtrOff  = 21'(2 * IMG_W + 2);

   // Symmetric kernels stored as (edge, near, middle) taps, kernels 1..4.
   localparam int unsigned KEdge [4] = '{1, 2, 4, 5};
   localparam int unsigned KNear [4] = '{4, 7, 7, 7};
   localparam int unsigned KMid  [4] = '{22, 14, 10, 8};

   logic unused_clk_90;
   assign unused_clk_90 = clk_90;

   function automatic logic [12:0] vsum(input logic [4:0][7:0] w, input logic [1:0] k);
      return 13'(KEdge[k] * (32'(w[0]) + 32'(w[4])) + KNear[k] * (32'(w[1]) + 32'(w[3]))
                 + KMid[k] * 32'(w[2]));
   endfunction

   function automatic logic [17:0] hsum(input logic [4:0][12:0] v, input logic [1:0] k);
      return 18'(KEdge[k] * (32'(v[0]) + 32'(v[4])) + KNear[k] * (32'(v[1]) + 32'(v[3]))
                 + KMid[k] * 32'(v[2]));
   endfunction

   function automatic logic [7:0] adiff(input logic [17:0] a, input logic [17:0] b);
      logic [17:0] d;
      d = (a >= b) ? a - b : b - a;
      return d[17:10];
   endfunction

   // Raster position of the pixel currently on din.
   logic [CW-1:0] col_q;
   logic [RW-1:0] row_q;
   logic [20:0]   idx_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_q <= '0;
         row_q <= '0;
         idx_q <= '0;
      end else begin
         if (col_q == ColLast) begin
            col_q <= '0;
            row_q <= (row_q == RowLast) ? '0 : row_q + RW'(1);
         end else begin
            col_q <= col_q + CW'(1);
         end
         idx_q <= (idx_q == PixLast) ? '0 : idx_q + 21'd1;
      end
   end

   // Cascaded line buffers: lb_mem[i][c] holds the pixel i+1 rows above the current one.
   // Never cleared; stale rows only feed windows that are masked invalid.
   logic [7:0] lb_mem [4][IMG_W];

   always_ff @(posedge clk) begin
      lb_mem[0][col_q] <= din;
      lb_mem[1][col_q] <= lb_mem[0][col_q];
      lb_mem[2][col_q] <= lb_mem[1][col_q];
      lb_mem[3][col_q] <= lb_mem[2][col_q];
   end

   // Stage 0: column capture. Stage 1: vertical sums with 5-column history.
   // Stage 2: horizontal sums and differences. Stage 3: output registers.
   logic [4:0][7:0]        win_q;
   logic [3:0][4:0][12:0]  vs_q;
   logic [3:0][17:0]       h_d;
   logic [3:0][17:0]       h_q;
   logic [2:0][7:0]        df_q;
   logic                   v0_q, v1_q, v2_q;
   logic                   l0_q, l1_q, l2_q;
   logic [20:0]            a0_q, a1_q, a2_q;

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         h_d[k] = hsum(vs_q[k], 2'(k));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         win_q     <= '0;
         vs_q      <= '0;
         h_q       <= '0;
         df_q      <= '0;
         v0_q      <= 1'b0;
         v1_q      <= 1'b0;
         v2_q      <= 1'b0;
         l0_q      <= 1'b0;
         l1_q      <= 1'b0;
         l2_q      <= 1'b0;
         a0_q      <= '0;
         a1_q      <= '0;
         a2_q      <= '0;
         dout1     <= '0;
         dout2     <= '0;
         dout3     <= '0;
         dout4     <= '0;
         diff0     <= '0;
         diff1     <= '0;
         diff2     <= '0;
         out_en    <= 1'b0;
         addr      <= '0;
         complete1 <= 1'b0;
         complete2 <= 1'b0;
      end else begin
         win_q <= {lb_mem[3][col_q], lb_mem[2][col_q], lb_mem[1][col_q], lb_mem[0][col_q], din};
         v0_q  <= (row_q >= RW'(4)) && (col_q >= CW'(4));
         l0_q  <= (idx_q == PixLast);
         a0_q  <= idx_q - CtrOff;

         for (int k = 0; k < 4; k++) begin
            vs_q[k] <= {vs_q[k][3:0], vsum(win_q, 2'(k))};
         end
         v1_q <= v0_q;
         l1_q <= l0_q;
         a1_q <= a0_q;

         h_q     <= h_d;
         df_q[0] <= adiff(h_d[0], h_d[1]);
         df_q[1] <= adiff(h_d[1], h_d[2]);
         df_q[2] <= adiff(h_d[2], h_d[3]);
         v2_q    <= v1_q;
         l2_q    <= l1_q;
         a2_q    <= a1_q;

         dout1     <= h_q[0];
         dout2     <= h_q[1];
         dout3     <= h_q[2];
         dout4     <= h_q[3];
         diff0     <= df_q[0];
         diff1     <= df_q[1];
         diff2     <= df_q[2];
         out_en    <= v2_q;
         addr      <= a2_q;
         complete1 <= l2_q;
         complete2 <= l2_q & v2_q;
      end
   end

endmodule

// File: tb/tb_dog.sv
// Scoreboard bench for dog on an 8x6 frame: reset, constant, impulse, ramp, saturation and
// mid-frame reset. Stimulus pushes expected outputs with their due cycle; a monitor pops them.
module tb_dog;

   localparam int unsigned W = 8;
   localparam int unsigned H = 6;
   localparam int MConst = 0;
   localparam int MImp   = 1;
   localparam int MRamp  = 2;
   localparam int MSat   = 3;

   logic        clk = 1'b0;
   logic        clk_90 = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  din = 8'd0;
   logic [17:0] dout1, dout2, dout3, dout4;
   logic [7:0]  diff0, diff1, diff2;
   logic        out_en;
   logic [20:0] addr;
   logic        complete1, complete2;

   dog #(
      .IMG_W(W),
      .IMG_H(H)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .clk_90    (clk_90),
      .din       (din),
      .dout1     (dout1),
      .dout2     (dout2),
      .dout3     (dout3),
      .dout4     (dout4),
      .diff0     (diff0),
      .diff1     (diff1),
      .diff2     (diff2),
      .out_en    (out_en),
      .addr      (addr),
      .complete1 (complete1),
      .complete2 (complete2)
   );

   always #5 clk = ~clk;
   initial begin
      #3;
      forever #5 clk_90 = ~clk_90;
   end

   typedef struct {
      int unsigned cyc;
      logic [20:0] addr;
      logic [17:0] d1, d2, d3, d4;
      logic [7:0]  f0, f1, f2;
      logic        cmpl;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          failures = 0;
   int unsigned cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Impulse of 255 at window offset (dr, dc) from the centre; values worked out by hand.
   function automatic exp_t imp_exp(input int dr, input int dc);
      exp_t e;
      e = '{cyc: 0, addr: '0, d1: '0, d2: '0, d3: '0, d4: '0, f0: '0, f1: '0, f2: '0, cmpl: 1'b0};
      case (dr * 4 + dc)
         0: begin e.d1 = 123420; e.d2 = 49980; e.d3 = 25500; e.d4 = 16320;
                  e.f0 = 71; e.f1 = 23; e.f2 = 8; end  // 9180/1024 floors to 8
         1, 4: begin e.d1 = 22440; e.d2 = 24990; e.d3 = 17850; e.d4 = 14280;
                  e.f0 = 2; e.f1 = 6; e.f2 = 3; end
         2: begin e.d1 = 5610; e.d2 = 7140; e.d3 = 10200; e.d4 = 10200;
                  e.f0 = 1; e.f1 = 2; e.f2 = 0; end
         5: begin e.d1 = 4080; e.d2 = 12495; e.d3 = 12495; e.d4 = 12495;
                  e.f0 = 8; e.f1 = 0; e.f2 = 0; end
         6: begin e.d1 = 1020; e.d2 = 3570; e.d3 = 7140; e.d4 = 8925;
                  e.f0 = 2; e.f1 = 3; e.f2 = 1; end
         default: ;
      endcase
      return e;
   endfunction

   function automatic exp_t make_exp(input int mode, input int base, input int r, input int c);
      exp_t e;
      logic [17:0] v;
      if (mode == MImp) begin
         e = imp_exp(r - 4, c - 4);
      end else begin
         case (mode)
            MConst:  v = 18'd102400;
            MSat:    v = 18'd261120;
            // A linear ramp under a symmetric kernel gives 1024 x the centre pixel.
            default: v = 18'(1024 * (base + (r - 2) * int'(W) + (c - 2)));
         endcase
         e = '{cyc: 0, addr: '0, d1: v, d2: v, d3: v, d4: v, f0: '0, f1: '0, f2: '0, cmpl: 1'b0};
      end
      e.addr = 21'((r - 2) * int'(W) + (c - 2));
      e.cmpl = (r == int'(H) - 1) && (c == int'(W) - 1);
      return e;
   endfunction

   // Called at a falling edge; drives one frame (or up to pixel index stop) one pixel per clk.
   task automatic run_frame(input int mode, input int base, input int stop);
      exp_t e;
      for (int r = 0; r < int'(H); r++) begin
         for (int c = 0; c < int'(W); c++) begin
            if (stop >= 0 && r * int'(W) + c > stop) return;
            case (mode)
               MConst:  din = 8'd100;
               MImp:    din = (r == 2 && c == 2) ? 8'd255 : 8'd0;
               MSat:    din = 8'd255;
               default: din = 8'(base + r * int'(W) + c);
            endcase
            if (r >= 4 && c >= 4) begin
               e = make_exp(mode, base, r, c);
               e.cyc = cyc + 4;
               sb.push_back(e);
            end
            @(negedge clk);
         end
      end
   endtask

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            checks++;
            if ({dout1, dout2, dout3, dout4, diff0, diff1, diff2, out_en, addr, complete1,
                 complete2} != '0) begin
               failures++;
               $display("FAIL reset_zero: out_en=%b addr=%0d dout1=%0d diff0=%0d got nonzero, required 0",
                        out_en, addr, dout1, diff0);
            end
         end else begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
               checks++;
               failures++;
               $display("FAIL missing_out: addr=%0d due at cyc %0d, not seen by cyc %0d",
                        sb[0].addr, sb[0].cyc, cyc);
               void'(sb.pop_front());
            end
            checks++;
            if (out_en) begin
               if (sb.size() == 0 || sb[0].cyc != cyc) begin
                  failures++;
                  $display("FAIL unexpected_out: out_en=1 addr=%0d at cyc %0d, required out_en=0",
                           addr, cyc);
               end else begin
                  e = sb.pop_front();
                  if ({addr, dout1, dout2, dout3, dout4, diff0, diff1, diff2, complete1, complete2}
                      != {e.addr, e.d1, e.d2, e.d3, e.d4, e.f0, e.f1, e.f2, e.cmpl, e.cmpl}) begin
                     failures++;
                     $display("FAIL out_data: got addr=%0d d=%0d/%0d/%0d/%0d f=%0d/%0d/%0d c=%b%b required addr=%0d d=%0d/%0d/%0d/%0d f=%0d/%0d/%0d c=%b%b",
                              addr, dout1, dout2, dout3, dout4, diff0, diff1, diff2, complete1,
                              complete2, e.addr, e.d1, e.d2, e.d3, e.d4, e.f0, e.f1, e.f2,
                              e.cmpl, e.cmpl);
                  end
               end
            end else if (complete1 || complete2) begin
               failures++;
               $display("FAIL complete_idle: complete1=%b complete2=%b with out_en=0, required 0",
                        complete1, complete2);
            end
         end
      end
   end

   // Stimulus
   initial begin
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         din = 8'(i * 37 + 5);
         @(negedge clk);
      end
      rst = 1'b1;
      run_frame(MConst, 0, -1);
      run_frame(MImp, 0, -1);
      run_frame(MRamp, 0, -1);
      run_frame(MRamp, int'(W * H), -1);
      run_frame(MSat, 0, -1);

      // Reset while row 4 outputs are on the port.
      run_frame(MConst, 0, int'(4 * W + 7));
      din = 8'd0;
      #2;
      rst = 1'b0;
      sb.delete();
      #1;
      checks++;
      if ({out_en, dout1, diff0, addr, complete1, complete2} != '0) begin
         failures++;
         $display("FAIL async_reset: out_en=%b dout1=%0d addr=%0d, required all 0",
                  out_en, dout1, addr);
      end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      run_frame(MConst, 0, -1);

      for (int i = 0; i < 6; i++) begin
         din = 8'd0;
         @(negedge clk);
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d outputs still pending, required 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
